// File: rtl/gate_resp_checker_if.sv
// ---------------------------------------------------------------------------
// gate_resp_checker_if
//   Bundles the stimulus/response signals exchanged between the test-vector
//   environment and the gate response checker.
//
//   master modport (environment side):
//     drives  en, clr, gate_sel[2:0], in0, in1, dut_out
//     reads   mismatch, err_vec[1:0], chk_cnt[CW-1:0], fail_cnt[CW-1:0],
//             sweep_done, sweep_ok, all_ok
//   slave modport (checker side): the same signals with directions reversed.
// ---------------------------------------------------------------------------
interface gate_resp_checker_if #(
  parameter int unsigned CW = 8
);
  logic          en;
  logic          clr;
  logic [2:0]    gate_sel;
  logic          in0;
  logic          in1;
  logic          dut_out;
  logic          mismatch;
  logic [1:0]    err_vec;
  logic [CW-1:0] chk_cnt;
  logic [CW-1:0] fail_cnt;
  logic          sweep_done;
  logic          sweep_ok;
  logic          all_ok;

  modport master (
    output en, clr, gate_sel, in0, in1, dut_out,
    input  mismatch, err_vec, chk_cnt, fail_cnt, sweep_done, sweep_ok, all_ok
  );

  modport slave (
    input  en, clr, gate_sel, in0, in1, dut_out,
    output mismatch, err_vec, chk_cnt, fail_cnt, sweep_done, sweep_ok, all_ok
  );
endinterface

// File: rtl/gate_resp_checker.sv
// ---------------------------------------------------------------------------
// gate_resp_checker
//   Watches the generator's {in1,in0} vector and the logic-gate UUT output.
//   Each new vector must stay stable for SETTLE cycles; the UUT output is
//   then sampled once and compared with the truth table chosen by gate_sel.
//   Checks and failures are counted (saturating), and a per-sweep verdict is
//   reported once all four input combinations have been checked.
//
//   Ports:
//     clk  - system clock (shared with the generator)
//     rst  - asynchronous active-low reset
//     bus  - gate_resp_checker_if.slave:
//              en, clr, gate_sel, in0, in1, dut_out   (inputs)
//              mismatch, err_vec, chk_cnt, fail_cnt,
//              sweep_done, sweep_ok, all_ok           (outputs)
//
//   Parameters:
//     SETTLE - stable cycles required before sampling (1..255)
//     CW     - width of the saturating check/fail counters
// ---------------------------------------------------------------------------
module gate_resp_checker #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned CW     = 8
) (
  input  logic                clk,
  input  logic                rst,
  gate_resp_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONEV
  } state_t;

  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  state_t        state_q, state_d;
  logic [1:0]    vec_q, vec_d;
  logic [7:0]    settle_cnt_q, settle_cnt_d;
  logic [2:0]    gsel_q, gsel_d;
  logic [3:0]    mask_q, mask_d;
  logic          sweep_fail_q, sweep_fail_d;
  logic          mismatch_q, mismatch_d;
  logic [1:0]    err_vec_q, err_vec_d;
  logic [CW-1:0] chk_cnt_q, chk_cnt_d;
  logic [CW-1:0] fail_cnt_q, fail_cnt_d;
  logic          sweep_done_q, sweep_done_d;
  logic          sweep_ok_q, sweep_ok_d;
  logic          all_ok_q, all_ok_d;

  logic [1:0]    cur_vec;
  logic [3:0]    vec_onehot;
  logic          expected;
  logic          wrong;

  assign cur_vec    = {bus.in1, bus.in0};
  assign vec_onehot = 4'b0001 << vec_q;

  // Reference response for the registered vector and captured gate select.
  always_comb begin
    expected = 1'b0;
    case (gsel_q)
      3'd0:    expected =   vec_q[1] & vec_q[0];
      3'd1:    expected =   vec_q[1] | vec_q[0];
      3'd2:    expected = ~(vec_q[1] & vec_q[0]);
      3'd3:    expected = ~(vec_q[1] | vec_q[0]);
      3'd4:    expected =   vec_q[1] ^ vec_q[0];
      3'd5:    expected = ~(vec_q[1] ^ vec_q[0]);
      3'd6:    expected =   vec_q[0];
      default: expected =  ~vec_q[0];
    endcase
  end

  assign wrong = (bus.dut_out != expected);

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    settle_cnt_d = settle_cnt_q;
    gsel_d       = gsel_q;
    mask_d       = mask_q;
    sweep_fail_d = sweep_fail_q;
    mismatch_d   = 1'b0;
    err_vec_d    = err_vec_q;
    chk_cnt_d    = chk_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    sweep_done_d = 1'b0;
    sweep_ok_d   = sweep_ok_q;
    all_ok_d     = all_ok_q;

    if (bus.clr) begin
      state_d      = S_IDLE;
      settle_cnt_d = '0;
      mask_d       = '0;
      sweep_fail_d = 1'b0;
      err_vec_d    = '0;
      chk_cnt_d    = '0;
      fail_cnt_d   = '0;
      all_ok_d     = 1'b1;
    end else if (!bus.en) begin
      // Abandon any sweep in progress; results so far are kept.
      state_d      = S_IDLE;
      mask_d       = '0;
      sweep_fail_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Whatever vector is present when enabled counts as a fresh one.
          vec_d        = cur_vec;
          settle_cnt_d = '0;
          gsel_d       = bus.gate_sel;
          state_d      = S_SETTLE;
        end

        S_SETTLE: begin
          if (cur_vec != vec_q) begin
            vec_d        = cur_vec;
            settle_cnt_d = '0;
          end else if (settle_cnt_q == SETTLE_LAST) begin
            state_d = S_CHECK;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end

        S_CHECK: begin
          if (cur_vec != vec_q) begin
            // Vector moved before the sample edge: it is not checked.
            vec_d        = cur_vec;
            settle_cnt_d = '0;
            state_d      = S_SETTLE;
          end else begin
            state_d = S_DONEV;
            if (chk_cnt_q != CNT_MAX) chk_cnt_d = chk_cnt_q + 1'b1;
            if (wrong) begin
              if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
              mismatch_d   = 1'b1;
              err_vec_d    = vec_q;
              all_ok_d     = 1'b0;
              sweep_fail_d = 1'b1;
            end
            if ((mask_q | vec_onehot) == 4'b1111) begin
              // The failure of this very check must be folded into the verdict.
              sweep_done_d = 1'b1;
              sweep_ok_d   = ~(sweep_fail_q | wrong);
              mask_d       = '0;
              sweep_fail_d = 1'b0;
            end else begin
              mask_d = mask_q | vec_onehot;
            end
          end
        end

        S_DONEV: begin
          if (cur_vec != vec_q) begin
            vec_d        = cur_vec;
            settle_cnt_d = '0;
            state_d      = S_SETTLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      settle_cnt_q <= '0;
      gsel_q       <= '0;
      mask_q       <= '0;
      sweep_fail_q <= 1'b0;
      mismatch_q   <= 1'b0;
      err_vec_q    <= '0;
      chk_cnt_q    <= '0;
      fail_cnt_q   <= '0;
      sweep_done_q <= 1'b0;
      sweep_ok_q   <= 1'b0;
      all_ok_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_cnt_q <= settle_cnt_d;
      gsel_q       <= gsel_d;
      mask_q       <= mask_d;
      sweep_fail_q <= sweep_fail_d;
      mismatch_q   <= mismatch_d;
      err_vec_q    <= err_vec_d;
      chk_cnt_q    <= chk_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      sweep_done_q <= sweep_done_d;
      sweep_ok_q   <= sweep_ok_d;
      all_ok_q     <= all_ok_d;
    end
  end

  assign bus.mismatch   = mismatch_q;
  assign bus.err_vec    = err_vec_q;
  assign bus.chk_cnt    = chk_cnt_q;
  assign bus.fail_cnt   = fail_cnt_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.sweep_ok   = sweep_ok_q;
  assign bus.all_ok     = all_ok_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_resp_checker
//   Directed bench for gate_resp_checker. The main instance (SETTLE=4, CW=8)
//   covers reset, pass/fail sweeps, settle glitches, clear and reset in
//   operation. A second instance (CW=3) is driven with an always-wrong
//   response to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_gate_resp_checker;

  logic clk;
  logic rst;

  gate_resp_checker_if #(.CW(8)) m_if ();
  gate_resp_checker_if #(.CW(3)) s_if ();

  gate_resp_checker #(.SETTLE(4), .CW(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if.slave)
  );

  gate_resp_checker #(.SETTLE(4), .CW(3)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int m_mis_pulses   = 0;
  int m_sweep_pulses = 0;
  logic m_last_ok    = 1'b0;
  int s_mis_pulses   = 0;

  // Pulses are one cycle wide, so sampling on the falling edge sees each once.
  always @(negedge clk) begin
    if (m_if.mismatch) m_mis_pulses++;
    if (m_if.sweep_done) begin
      m_sweep_pulses++;
      m_last_ok = m_if.sweep_ok;
    end
    if (s_if.mismatch) s_mis_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Truth tables indexed by {in1,in0}.
  function automatic logic tt_bit(input logic [2:0] sel, input logic [1:0] v);
    logic [3:0] tab;
    case (sel)
      3'd0:    tab = 4'b1000;
      3'd1:    tab = 4'b1110;
      3'd2:    tab = 4'b0111;
      3'd3:    tab = 4'b0001;
      3'd4:    tab = 4'b0110;
      3'd5:    tab = 4'b1001;
      3'd6:    tab = 4'b1010;
      default: tab = 4'b0101;
    endcase
    return tab[v];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a vector to the main instance with a correct or wrong response.
  task automatic drive(input logic [1:0] v, input bit bad, input int n);
    m_if.in0     = v[0];
    m_if.in1     = v[1];
    m_if.dut_out = tt_bit(m_if.gate_sel, v) ^ bad;
    $display("vec %b bad=%0d hold=%0d chk=%0d fail=%0d", v, bad, n, m_if.chk_cnt, m_if.fail_cnt);
    tick(n);
  endtask

  task automatic drive_sat(input logic [1:0] v, input int n);
    s_if.in0     = v[0];
    s_if.in1     = v[1];
    s_if.dut_out = ~tt_bit(s_if.gate_sel, v);
    $display("sat vec %b hold=%0d chk=%0d fail=%0d", v, n, s_if.chk_cnt, s_if.fail_cnt);
    tick(n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    m_if.en = 1'b0; m_if.clr = 1'b0; m_if.gate_sel = 3'd0;
    m_if.in0 = 1'b0; m_if.in1 = 1'b0; m_if.dut_out = 1'b0;
    s_if.en = 1'b0; s_if.clr = 1'b0; s_if.gate_sel = 3'd1;
    s_if.in0 = 1'b0; s_if.in1 = 1'b0; s_if.dut_out = 1'b0;

    // Reset and idle
    tick(3);
    check("rst_all_ok", m_if.all_ok, 1);
    check("rst_chk_cnt", m_if.chk_cnt, 0);
    rst = 1'b1;
    tick(20);
    check("idle_mismatch", m_if.mismatch, 0);
    check("idle_err_vec", m_if.err_vec, 0);
    check("idle_chk_cnt", m_if.chk_cnt, 0);
    check("idle_fail_cnt", m_if.fail_cnt, 0);
    check("idle_sweep_done", m_if.sweep_done, 0);
    check("idle_sweep_ok", m_if.sweep_ok, 0);
    check("idle_all_ok", m_if.all_ok, 1);

    // Pass sweep, AND
    m_if.gate_sel = 3'd0;
    m_if.en = 1'b1;
    drive(2'b00, 0, 10);
    drive(2'b01, 0, 10);
    drive(2'b10, 0, 10);
    drive(2'b11, 0, 10);
    check("and_chk_cnt", m_if.chk_cnt, 4);
    check("and_fail_cnt", m_if.fail_cnt, 0);
    check("and_sweeps", m_sweep_pulses, 1);
    check("and_sweep_ok", m_last_ok, 1);
    check("and_all_ok", m_if.all_ok, 1);
    check("and_mis_pulses", m_mis_pulses, 0);

    // Fault injection, XOR wrong on 11
    m_if.en = 1'b0;
    drive(2'b00, 0, 2);
    m_if.gate_sel = 3'd4;
    m_if.en = 1'b1;
    drive(2'b00, 0, 10);
    drive(2'b01, 0, 10);
    drive(2'b10, 0, 10);
    drive(2'b11, 1, 10);
    check("xor_mis_pulses", m_mis_pulses, 1);
    check("xor_err_vec", m_if.err_vec, 3);
    check("xor_fail_cnt", m_if.fail_cnt, 1);
    check("xor_chk_cnt", m_if.chk_cnt, 8);
    check("xor_sweeps", m_sweep_pulses, 2);
    check("xor_sweep_ok", m_last_ok, 0);
    check("xor_all_ok", m_if.all_ok, 0);
    drive(2'b00, 0, 10);
    drive(2'b01, 0, 10);
    drive(2'b10, 0, 10);
    drive(2'b11, 0, 10);
    check("clean_sweeps", m_sweep_pulses, 3);
    check("clean_sweep_ok", m_last_ok, 1);
    check("clean_all_ok", m_if.all_ok, 0);
    check("clean_chk_cnt", m_if.chk_cnt, 12);

    // Glitch: 01 held only 2 cycles is never checked
    drive(2'b01, 0, 2);
    drive(2'b10, 0, 8);
    check("glitch_chk_cnt", m_if.chk_cnt, 13);
    drive(2'b00, 0, 10);
    drive(2'b11, 0, 10);
    check("glitch_no_sweep", m_sweep_pulses, 3);
    check("glitch_chk_cnt2", m_if.chk_cnt, 15);
    drive(2'b01, 0, 10);
    check("glitch_sweep", m_sweep_pulses, 4);
    check("glitch_chk_cnt3", m_if.chk_cnt, 16);

    // Clear mid-sweep
    drive(2'b00, 0, 10);
    drive(2'b01, 1, 10);
    check("pre_clr_fail", m_if.fail_cnt, 2);
    m_if.clr = 1'b1;
    tick(1);
    m_if.clr = 1'b0;
    check("clr_chk_cnt", m_if.chk_cnt, 0);
    check("clr_fail_cnt", m_if.fail_cnt, 0);
    check("clr_err_vec", m_if.err_vec, 0);
    check("clr_all_ok", m_if.all_ok, 1);
    drive(2'b01, 0, 10);
    drive(2'b10, 0, 10);
    drive(2'b11, 0, 10);
    check("clr_no_sweep", m_sweep_pulses, 4);
    check("clr_chk_cnt2", m_if.chk_cnt, 3);
    drive(2'b00, 0, 10);
    check("clr_sweep", m_sweep_pulses, 5);
    check("clr_sweep_ok", m_last_ok, 1);
    check("clr_chk_cnt3", m_if.chk_cnt, 4);

    // Reset while settling, after two further checks
    drive(2'b01, 0, 10);
    drive(2'b10, 1, 10);
    check("pre_rst_chk", m_if.chk_cnt, 6);
    check("pre_rst_all_ok", m_if.all_ok, 0);
    drive(2'b11, 0, 2);
    rst = 1'b0;
    #2;
    check("arst_chk_cnt", m_if.chk_cnt, 0);
    check("arst_fail_cnt", m_if.fail_cnt, 0);
    check("arst_all_ok", m_if.all_ok, 1);
    #1;
    rst = 1'b1;
    tick(10);
    check("post_rst_chk", m_if.chk_cnt, 1);
    check("post_rst_fail", m_if.fail_cnt, 0);

    // Saturation on the CW=3 instance
    m_if.en = 1'b0;
    check("sat_start", s_if.chk_cnt, 0);
    s_if.en = 1'b1;
    for (int i = 0; i < 6; i++) drive_sat(2'(i % 4), 8);
    check("sat_chk6", s_if.chk_cnt, 6);
    check("sat_fail6", s_if.fail_cnt, 6);
    for (int i = 6; i < 10; i++) drive_sat(2'(i % 4), 8);
    check("sat_chk", s_if.chk_cnt, 7);
    check("sat_fail", s_if.fail_cnt, 7);
    check("sat_pulses", s_mis_pulses, 10);
    check("sat_all_ok", s_if.all_ok, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Downstream stage of the clock-divided test-vector generator; watches the generator's in0/in1 and the logic-gate unit-under-test output.
- After each vector change, waits a settle window, samples the UUT output and compares it with the truth table selected by gate_sel.
- Counts checks and failures, and reports per-sweep pass/fail once all four input combinations have been checked.

Parameters:
SETTLE, 4, clk cycles the vector must stay stable before the UUT output is sampled; legal range 1..255.
CW, 8, width of check and fail counters; both saturate at 2^CW-1.

Ports:
clk  input  1  system clock (same clock that drives the generator)
rst  input  1  asynchronous active-low reset
en  input  1  checker enable; high = run
clr  input  1  synchronous clear of counters and sticky flags; highest priority after rst
gate_sel  input  3  expected function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF(in0), 7 NOT(in0)
in0  input  1  test vector bit 0 from generator
in1  input  1  test vector bit 1 from generator
dut_out  input  1  UUT response
mismatch  output  1  one-cycle pulse: the sample just taken was wrong
err_vec  output  2  {in1,in0} of the most recent mismatch
chk_cnt  output  CW  checks performed, saturating
fail_cnt  output  CW  mismatches, saturating
sweep_done  output  1  one-cycle pulse: all four vectors checked in the current sweep
sweep_ok  output  1  valid with sweep_done; 1 = no mismatch in that sweep
all_ok  output  1  sticky; drops to 0 on the first mismatch, restored only by rst/clr

Behaviour:
- Reset (rst low, async): state IDLE; every output 0 except all_ok=1; vec_r=0, seen mask=0, sweep_fail=0, settle_cnt=0.
- clr high at an edge:
  - Same reset values for counters, err_vec, all_ok=1, mask, sweep_fail.
  - state->IDLE; mismatch and sweep_done forced 0.
- gate_sel is captured into gsel_r on the edge leaving IDLE. Changes while running are ignored until the next IDLE exit.
- States IDLE, SETTLE, CHECK:
  - IDLE: if en=1, then vec_r<={in1,in0}, settle_cnt<=0, go to SETTLE. The current vector is treated as new.
  - SETTLE:
    - If {in1,in0}!=vec_r: vec_r<=new value, settle_cnt<=0, stay in SETTLE (restart).
    - Else if settle_cnt==SETTLE-1: go to CHECK.
    - Else settle_cnt++.
  - CHECK (one cycle): at this edge, compare dut_out with f(gsel_r, vec_r), update counters, then go to WAIT_CHANGE behaviour, i.e. remain in CHECK-done substate (state DONEV) until {in1,in0}!=vec_r. On that change: vec_r<=new, settle_cnt<=0, go to SETTLE.
  - DONEV: holds, no further sampling of the same vector. If SETTLE window is violated by a change, the vector is not checked; no count.
- Check-edge updates:
  - chk_cnt++ (saturating).
  - On mismatch: fail_cnt++ (saturating), mismatch<=1 for exactly one cycle, err_vec<=vec_r, all_ok<=0, sweep_fail<=1.
  - mask[vec_r]<=1. Rechecking an already-seen vector counts normally and leaves the mask unchanged.
- Sweep completion:
  - If mask|onehot(vec_r)==4'b1111 at a check edge: sweep_done<=1 for one cycle, sweep_ok<=~(sweep_fail|mismatch_now).
  - Same edge clears mask and sweep_fail.
  - sweep_ok holds until the next sweep_done.
- en low at any edge: state->IDLE, mask and sweep_fail cleared, counters/all_ok/err_vec held, no pulses. A sweep in progress is abandoned.
- Latency: response sampled SETTLE+1 clk edges after the edge that first registers a new stable vector. mismatch and sweep_done appear on the cycle after that check edge.
- rst low mid-operation: immediate return to reset values regardless of state.

Test Plan:
- Reset and idle: rst low, then high with en=0 for 20 cycles -> all outputs 0 except all_ok=1; chk_cnt stays 0.
- Pass sweep: gate_sel=0 (AND), correct AND model, vectors 00,01,10,11 each held 10 cycles, SETTLE=4 -> chk_cnt=4, fail_cnt=0, one sweep_done with sweep_ok=1, all_ok=1.
- Fault injection: gate_sel=4 (XOR), model wrong only on 11 (outputs 1) -> one mismatch pulse, err_vec=2'b11, fail_cnt=1, sweep_done with sweep_ok=0, all_ok=0. The following clean sweep gives sweep_ok=1 while all_ok stays 0.
- Glitch in settle: vector 01 held 2 cycles, then 10 held 8 cycles (SETTLE=4) -> 01 never checked; chk_cnt increments once, for 10; mask does not include 01.
- Saturation: CW=3, always-wrong model, 10 vectors -> chk_cnt and fail_cnt stick at 7; mismatch still pulses every check.
- Reset and clear mid-operation:
  - rst low in SETTLE after 2 vectors checked -> counters 0, all_ok=1, state IDLE.
  - Separately, clr pulse mid-sweep -> mask cleared; the next sweep needs all 4 vectors before sweep_done.
